lemming_tunnel_arbiter: RTL
===========================

// Module: lemming_tunnel_arbiter
// PURPOSE
// - Round-robin arbiter sharing one single-lane tunnel among N_LEM lemming walker FSMs.
// - Each requester raises req[i] with its walk direction dir[i] (0 = walking left, 1 = walking right).
// - Grants one lemming at a time for a fixed transit time, then enforces a lane gap before the next grant.
// - lane_walk_left / lane_walk_right drive the tunnel-lane walker indicators.
// PARAMETERS
// - N_LEM    4  number of requesting lemmings (>=2)
// - TRANSIT  8  cycles grant is held per crossing (>=1)
// - GAP      2  idle cycles between successive grants (>=0)
// PORTS
// - clk              in   1      clock, rising edge
// - rst_n            in   1      reset, asynchronous, active-low
// - req              in   N_LEM  request to cross, level, one bit per lemming
// - dir              in   N_LEM  direction of each requester, sampled at grant
// - grant            out  N_LEM  one-hot (or zero) crossing grant, registered
// - busy             out  1      tunnel occupied (= |grant)
// - cur_dir          out  1      direction of current/last crossing
// - lane_walk_left   out  1      busy & ~cur_dir
// - lane_walk_right  out  1      busy & cur_dir
// - transit_done     out  1      1-cycle pulse in the final grant cycle
// BEHAVIOUR
// - Reset (async): grant=0, busy=0, cur_dir=0, transit_done=0, rr pointer=0, state=IDLE, counters=0.
//   Asserting rst_n low mid-transit drops grant immediately; the crossing is abandoned.
// - States: IDLE, PASS, GAP.
//   - IDLE: at each edge with |req, pick the winner, load counter TRANSIT-1, go to PASS.
//   - PASS: hold grant; the counter decrements each cycle; transit_done=1 when the counter is 0.
//   - On the edge ending the last PASS cycle:
//     - GAP>0: go to GAP, counter = GAP-1, grant=0.
//     - GAP=0: arbitrate immediately; a winner enters PASS back-to-back, no winner goes to IDLE.
//   - GAP: grant=0 for exactly GAP cycles. On the edge ending the last GAP cycle, arbitrate:
//     a winner enters PASS, no winner goes to IDLE.
// - Latency: req sampled at edge k gives grant high in the cycle after edge k (1 cycle from IDLE).
// - Arbitration:
//   - Search req from index ptr upward, wrapping modulo N_LEM.
//   - On grant to i: ptr <= (i+1) mod N_LEM, and cur_dir <= dir[i], captured once.
//   - Later changes to dir[i] are ignored for that crossing.
// - Committed crossing: deasserting req[i] during PASS does not shorten or cancel the grant.
// - A requester still asserting req after its crossing re-competes, behind others due to the pointer.
// - req and dir are ignored during PASS and GAP except at the arbitration edges above.
// - Simultaneous requests: exactly one grant; never more than one grant bit set.
// - Idle with no req: all outputs 0, cur_dir holds its last value.
// CONFIGURATION
// - Macro TUNNEL_SAME_DIR_CHAIN_EN.
//   - Defined: at the end of PASS, if the next winner's dir equals cur_dir, skip GAP and grant
//     back-to-back (same-direction lemmings follow each other through the lane).
//     Opposite direction still takes the full GAP.
//   - Undefined: GAP always applied regardless of direction.
// TESTING (defaults N_LEM=4, TRANSIT=8, GAP=2)
// - Single req: req=4'b0001, dir=0 at cycle 0.
//   -> grant=0001 cycles 1..8, lane_walk_left=1, transit_done at cycle 8, all outputs 0 from cycle 9.
// - All requests: req=4'b1111 held.
//   -> grants 0001,0010,0100,1000,0001 in order, each 8 cycles, 2-cycle zero gaps, period 10.
// - Drop during transit: req[2] granted, deasserted at grant cycle 3 -> grant stays 8 full cycles.
// - Chain: req[0] and req[1] with dir=1,1.
//   -> with TUNNEL_SAME_DIR_CHAIN_EN, grant 0010 immediately follows 0001, no gap.
//   -> without the macro, 2-cycle gap.
//   -> dir=1,0 gives a 2-cycle gap in both builds.
// - Reset mid-transit: rst_n low at grant cycle 4.
//   -> grant=0, busy=0 asynchronously.
//   -> after release with req=4'b1010, grant=0010 first (ptr=0).
// - Invariant: $onehot0(grant) every cycle; busy==|grant.
// - Invariant: lane_walk_left & lane_walk_right never both 1.

Source files
------------

// File: rtl/lemming_tunnel_arbiter.sv
// lemming_tunnel_arbiter
// Round-robin arbiter that shares one single-lane tunnel among N_LEM walker
// FSMs. A winner holds the lane for TRANSIT cycles. The lane then stays empty
// for GAP cycles before the next grant.
// Optional feature macro: TUNNEL_SAME_DIR_CHAIN_EN. When it is defined, a
// winner walking in the same direction as the lemming that just crossed
// follows it through the lane without the GAP.
module lemming_tunnel_arbiter #(
  parameter int N_LEM   = 4,
  parameter int TRANSIT = 8,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LEM-1:0] req,
  input  logic [N_LEM-1:0] dir,
  output logic [N_LEM-1:0] grant,
  output logic             busy,
  output logic             cur_dir,
  output logic             lane_walk_left,
  output logic             lane_walk_right,
  output logic             transit_done
);

  localparam int PW   = $clog2(N_LEM);
  localparam int MAXC = (TRANSIT > GAP) ? TRANSIT : GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TRANSIT_LOAD = CW'(TRANSIT - 1);
  // GAP=0 never enters the GAP state, so the load value is then irrelevant.
  localparam logic [CW-1:0] GAP_LOAD     = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [PW-1:0]    ptr_r, ptr_s;
  logic [N_LEM-1:0] grant_r, grant_s;
  logic             cur_dir_r, cur_dir_s;

  logic             win_found_s;
  logic [PW-1:0]    win_idx_s;
  logic             chain_s;
  logic             launch_s;

  // Round-robin search: first asserted req at or above ptr, wrapping around.
  always_comb begin
    logic [PW-1:0] idx_v;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    idx_v       = '0;
    for (int k = 0; k < N_LEM; k++) begin
      idx_v = PW'((int'(ptr_r) + k) % N_LEM);
      if (!win_found_s && req[idx_v]) begin
        win_found_s = 1'b1;
        win_idx_s   = idx_v;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Decide whether the next winner may follow the previous crossing without a gap.
  always_comb begin
`ifdef TUNNEL_SAME_DIR_CHAIN_EN
    chain_s = win_found_s && (dir[win_idx_s] == cur_dir_r);
`else
    chain_s = 1'b0;
`endif
  end

  // State register: holds FSM state, counter, pointer, grant and the latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      ptr_r     <= '0;
      grant_r   <= '0;
      cur_dir_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      ptr_r     <= ptr_s;
      grant_r   <= grant_s;
      cur_dir_r <= cur_dir_s;
    end
  end

  // Next-state logic: sequences IDLE -> PASS -> GAP and launches new crossings.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ptr_s     = ptr_r;
    grant_s   = grant_r;
    cur_dir_s = cur_dir_r;
    launch_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          launch_s = 1'b1;
        end else begin
          grant_s = '0;
        end
      end
      ST_PASS: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - CW'(1);
        end else if ((GAP == 0) || chain_s) begin
          if (win_found_s) begin
            launch_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
            grant_s = '0;
          end
        end else begin
          state_s = ST_GAP;
          cnt_s   = GAP_LOAD;
          grant_s = '0;
        end
      end
      ST_GAP: begin
        if (cnt_r != '0) begin
          cnt_s = cnt_r - CW'(1);
        end else if (win_found_s) begin
          launch_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        grant_s = '0;
      end
    endcase

    // Launch a crossing: direction is captured once and frozen for the transit.
    if (launch_s) begin
      state_s   = ST_PASS;
      cnt_s     = TRANSIT_LOAD;
      grant_s   = N_LEM'(1) << win_idx_s;
      ptr_s     = PW'((int'(win_idx_s) + 1) % N_LEM);
      cur_dir_s = dir[win_idx_s];
    end else begin
      launch_s  = 1'b0;
    end
  end

  // Output logic: all outputs derive only from registered state.
  always_comb begin
    grant           = grant_r;
    cur_dir         = cur_dir_r;
    busy            = |grant_r;
    lane_walk_left  = (|grant_r) & ~cur_dir_r;
    lane_walk_right = (|grant_r) &  cur_dir_r;
    transit_done    = (state_r == ST_PASS) && (cnt_r == '0);
  end

endmodule
